// File: rtl/mismatch_scoreboard.sv
// Purpose: compares a reference vector against a DUT vector on qualified cycles and keeps run statistics.
// Latency: statistics reflect a sample on the clock edge after it is presented (1 cycle).
// Backpressure: none; every qualified sample is accepted, counters saturate instead of wrapping.
module mismatch_scoreboard #(
    parameter int N_OUT  = 1,
    parameter int CNT_W  = 16,
    parameter int TIME_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              sample_valid,
    input  logic [N_OUT-1:0]  ref_vec,
    input  logic [N_OUT-1:0]  dut_vec,
    output logic [CNT_W-1:0]  samples,
    output logic [CNT_W-1:0]  errors,
    output logic [TIME_W-1:0] first_err_time,
    output logic [N_OUT-1:0]  err_mask,
    output logic              busy,
    output logic              done,
    output logic              passed
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [TIME_W-1:0] TIME_MAX = '1;
    localparam logic [TIME_W-1:0] TIME_ONE = TIME_W'(1);

    state_t             state_q;
    state_t             state_d;
    logic               stats_clr;
    logic               stats_upd;
    logic [TIME_W-1:0]  elapsed;
    logic [N_OUT-1:0]   diff_vec;
    logic               mismatch;

    assign diff_vec = ref_vec ^ dut_vec;
    assign mismatch = sample_valid && (ref_vec != dut_vec);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // start wins over stop in every state; a restart discards the sample of that cycle
    always_comb begin
        state_d   = state_q;
        stats_clr = 1'b0;
        stats_upd = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    stats_clr = 1'b1;
                end
            end
            RUN: begin
                if (start) begin
                    stats_clr = 1'b1;
                end else begin
                    stats_upd = 1'b1;
                    if (stop) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_d   = RUN;
                    stats_clr = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samples        <= '0;
            errors         <= '0;
            first_err_time <= '0;
            err_mask       <= '0;
            elapsed        <= '0;
        end else if (stats_clr) begin
            samples        <= '0;
            errors         <= '0;
            first_err_time <= '0;
            err_mask       <= '0;
            elapsed        <= '0;
        end else if (stats_upd) begin
            if (elapsed != TIME_MAX) begin
                elapsed <= elapsed + TIME_ONE;
            end
            if (sample_valid && (samples != CNT_MAX)) begin
                samples <= samples + CNT_ONE;
            end
            // the mask keeps accumulating even once the error count has saturated
            if (mismatch) begin
                err_mask <= err_mask | diff_vec;
                if (errors != CNT_MAX) begin
                    errors <= errors + CNT_ONE;
                end
                if (errors == '0) begin
                    first_err_time <= elapsed;
                end
            end
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign passed = done && (errors == '0) && (samples != '0);

endmodule
